// File: rtl/mvm_rx_pkg.sv
// rtl/mvm_rx_pkg.sv - shared op encoding and TUSER field positions for the MVM tile ingress
package mvm_rx_pkg;

  typedef enum logic [1:0] {
    OP_RSVD0 = 2'b00,
    OP_RSVD1 = 2'b01,
    OP_VEC   = 2'b10,
    OP_WGT   = 2'b11
  } mvm_op_e;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 8;
  localparam int OP_LSB   = 9;
  localparam int OP_MSB   = 10;
  localparam int MASK_LSB = 11;
  localparam int MASK_MSB = 74;

  localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

endpackage

// File: rtl/mvm_rx_vec_fifo.sv
// rtl/mvm_rx_vec_fifo.sv - synchronous input-vector FIFO with full/empty/count
module mvm_rx_vec_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_fire;
  logic             pop_fire;

  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign push_fire = push & ~full;
  assign pop_fire  = pop & ~empty;
  // Head is forced to zero when empty so the vector outputs read 0 after reset.
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push_fire) - CW'(pop_fire);
    end
  end

  // Storage array; no reset needed because empty masks stale contents.
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mvm_axis_rx_decoder.sv
// rtl/mvm_axis_rx_decoder.sv - MVM tile AXIS ingress: weight-write decode and vector FIFO (option MVM_RX_DEST_CHECK_EN)
module mvm_axis_rx_decoder
  import mvm_rx_pkg::*;
#(
  parameter int              DATAW          = 512,
  parameter int              USERW          = 75,
  parameter int              DESTW          = 12,
  parameter int              IDW            = 32,
  parameter int              NUM_RF         = 64,
  parameter int              VEC_FIFO_DEPTH = 4,
  parameter logic [DESTW-1:0] ROUTER_ID     = 12'h001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 axis_s_tvalid,
  output logic                 axis_s_tready,
  input  logic [DATAW-1:0]     axis_s_tdata,
  input  logic [USERW-1:0]     axis_s_tuser,
  input  logic [DESTW-1:0]     axis_s_tdest,
  input  logic [IDW-1:0]       axis_s_tid,
  input  logic                 axis_s_tlast,
  output logic [NUM_RF-1:0]    rf_wen,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATAW-1:0]     rf_wdata,
  output logic                 vec_valid,
  input  logic                 vec_ready,
  output logic [DATAW-1:0]     vec_data,
  output logic                 vec_last,
  output logic [15:0]          err_cnt
);

  localparam int CW = $clog2(VEC_FIFO_DEPTH) + 1;

  logic              tready_q;
  logic              accept;
  mvm_op_e           op;
  logic [NUM_RF-1:0] mask;
  logic              dest_ok;
  logic              wgt_fire;
  logic              vec_push;
  logic              drop;
  logic              pop_fire;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_nxt;
  logic [DATAW:0]    head;
  logic              unused_in;

`ifdef MVM_RX_DEST_CHECK_EN
  assign dest_ok   = (axis_s_tdest == ROUTER_ID);
  assign unused_in = ^axis_s_tid;
`else
  assign dest_ok   = 1'b1;
  assign unused_in = ^{axis_s_tid, axis_s_tdest, ROUTER_ID};
`endif

  assign axis_s_tready = tready_q;
  assign vec_valid     = ~fifo_empty;
  assign pop_fire      = vec_valid & vec_ready;
  assign vec_data      = head[DATAW-1:0];
  assign vec_last      = head[DATAW];

  // Per-beat decode: every accepted flit is a weight write, a vector push or a drop.
  always_comb begin
    accept    = axis_s_tvalid & tready_q & ~fifo_full;
    op        = mvm_op_e'(axis_s_tuser[OP_MSB:OP_LSB]);
    mask      = axis_s_tuser[MASK_LSB +: NUM_RF];
    wgt_fire  = 1'b0;
    vec_push  = 1'b0;
    if (accept && dest_ok) begin
      wgt_fire = (op == OP_WGT) && (mask != '0);
      vec_push = (op == OP_VEC);
    end
    drop      = accept & ~wgt_fire & ~vec_push;
    count_nxt = fifo_count + CW'(vec_push) - CW'(pop_fire);
  end

  // Ready is registered from the look-ahead occupancy so it never depends on the current flit.
  always_ff @(posedge clk) begin
    if (!rst_n) tready_q <= 1'b0;
    else        tready_q <= (count_nxt != CW'(VEC_FIFO_DEPTH));
  end

  // RF write port: one-cycle strobe after acceptance; address and data held between writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen   <= '0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= wgt_fire ? mask : '0;
      if (wgt_fire) begin
        rf_waddr <= axis_s_tuser[ADDR_MSB:ADDR_LSB];
        rf_wdata <= axis_s_tdata;
      end
    end
  end

  // Saturating count of dropped flits.
  always_ff @(posedge clk) begin
    if (!rst_n)                         err_cnt <= '0;
    else if (drop && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end

  mvm_rx_vec_fifo #(
    .WIDTH (DATAW + 1),
    .DEPTH (VEC_FIFO_DEPTH)
  ) u_vec_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vec_push),
    .push_data ({axis_s_tlast, axis_s_tdata}),
    .pop       (pop_fire),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
